// File: rtl/ofdm_subcarrier_map.sv
// rtl/ofdm_subcarrier_map.sv - OFDM subcarrier mapper: 48 data + 4 pilots onto 64 IFFT bins
//
// Collects 48 constellation samples per symbol into one of two ping-pong banks,
// then streams the 64 IFFT bins in natural order (0..63). Bins are filled with
// data, scrambled BPSK pilots (bins 7, 21, 43, 57) or zeros (bins 0, 27..37).
// Every output symbol is followed by a CP_LEN-cycle idle gap.
//
// Ports:
//   clk        working clock
//   aresetn    asynchronous active-low reset
//   new_frame  synchronous frame start; flushes both banks, restarts pilot LFSR
//   di_re/im   input data sample (signed, DW bits each)
//   di_vld     input valid
//   di_rdy     input ready; sample taken when di_vld & di_rdy
//   do_re/im   output bin sample (signed, DW bits each)
//   do_last    marks bin 63 of each symbol
//   do_vld     output valid (no backpressure)
module ofdm_subcarrier_map #(
  parameter int DW        = 12,
  parameter int CP_LEN    = 16,
  parameter int PILOT_AMP = 1024
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 new_frame,
  input  logic signed [DW-1:0] di_re,
  input  logic signed [DW-1:0] di_im,
  input  logic                 di_vld,
  output logic                 di_rdy,
  output logic signed [DW-1:0] do_re,
  output logic signed [DW-1:0] do_im,
  output logic                 do_last,
  output logic                 do_vld
);

  localparam int GW = $clog2(CP_LEN + 1);
  localparam logic signed [DW-1:0] AMP_POS = DW'(PILOT_AMP);
  localparam logic signed [DW-1:0] AMP_NEG = DW'(-PILOT_AMP);

  typedef enum logic [1:0] {IDLE, READ, GAP} state_t;

  state_t          state_q, state_d;
  logic [2*DW-1:0] mem [0:127];
  logic [1:0]      full, full_d;
  logic            wr_bank, rd_bank;
  logic [5:0]      wr_k, rd_cnt;
  logic [GW-1:0]   gap_cnt;
  logic            rst_done;
  logic            accept, rd_done;
  logic [6:0]      lfsr;
  logic            s1_vld, s1_last;
  logic [5:0]      s1_bin;
  logic [2*DW-1:0] s1_data;
  logic signed [DW-1:0] mux_re, mux_im;
  logic            pil_neg;

  // Data index k -> IFFT bin, skipping DC, pilots and the guard band.
  function automatic logic [5:0] bin_of(input logic [5:0] k);
    if (k < 6'd5)       return k + 6'd38;
    else if (k < 6'd18) return k + 6'd39;
    else if (k < 6'd24) return k + 6'd40;
    else if (k < 6'd30) return k + 6'd41;  // k-23 modulo 64
    else if (k < 6'd43) return k + 6'd42;  // k-22 modulo 64
    else                return k + 6'd43;  // k-21 modulo 64
  endfunction

  // di_rdy is held low until the first clock after reset release.
  assign di_rdy = rst_done & ~full[wr_bank];
  assign accept = di_vld & di_rdy & ~new_frame;

  always_comb begin
    state_d = state_q;
    rd_done = 1'b0;
    case (state_q)
      IDLE: if (full[rd_bank]) state_d = READ;
      READ: if (rd_cnt == 6'd63) begin
        rd_done = 1'b1;
        state_d = GAP;
      end
      GAP: if (gap_cnt == GW'(CP_LEN - 1)) begin
        // rd_bank has already toggled, so this looks at the next symbol.
        state_d = full[rd_bank] ? READ : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Write-side full and read-side clear always hit different banks.
  always_comb begin
    full_d = full;
    if (accept && wr_k == 6'd47) full_d[wr_bank] = 1'b1;
    if (rd_done)                 full_d[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)       state_q <= IDLE;
    else if (new_frame) state_q <= IDLE;
    else                state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (accept) mem[{wr_bank, bin_of(wr_k)}] <= {di_re, di_im};
    s1_data <= mem[{rd_bank, rd_cnt}];
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rst_done <= 1'b0;
      full     <= '0;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      wr_k     <= '0;
      rd_cnt   <= '0;
      gap_cnt  <= '0;
      lfsr     <= 7'h7F;
      s1_vld   <= 1'b0;
      s1_last  <= 1'b0;
      s1_bin   <= '0;
      do_vld   <= 1'b0;
      do_last  <= 1'b0;
      do_re    <= '0;
      do_im    <= '0;
    end else if (new_frame) begin
      rst_done <= 1'b1;
      full     <= '0;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      wr_k     <= '0;
      rd_cnt   <= '0;
      gap_cnt  <= '0;
      lfsr     <= 7'h7F;
      s1_vld   <= 1'b0;
      s1_last  <= 1'b0;
      s1_bin   <= '0;
      do_vld   <= 1'b0;
      do_last  <= 1'b0;
      do_re    <= '0;
      do_im    <= '0;
    end else begin
      rst_done <= 1'b1;
      full     <= full_d;
      if (accept) begin
        if (wr_k == 6'd47) begin
          wr_k    <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_k <= wr_k + 6'd1;
        end
      end
      if (rd_done) rd_bank <= ~rd_bank;
      rd_cnt  <= (state_q == READ) ? rd_cnt + 6'd1 : 6'd0;
      gap_cnt <= (state_q == GAP) ? gap_cnt + GW'(1) : '0;
      // Stage 1: bin index travels alongside the bank read.
      s1_vld  <= (state_q == READ);
      s1_last <= (state_q == READ) && (rd_cnt == 6'd63);
      s1_bin  <= rd_cnt;
      // Stage 2: registered output with null/pilot substitution.
      do_vld  <= s1_vld;
      do_last <= s1_vld & s1_last;
      do_re   <= s1_vld ? mux_re : '0;
      do_im   <= s1_vld ? mux_im : '0;
      // Pilots of the symbol are all issued before bin 63, so advancing here
      // keeps one polarity per symbol.
      if (s1_vld && s1_last) lfsr <= {lfsr[5:0], pil_neg};
    end
  end

  always_comb begin
    pil_neg = lfsr[6] ^ lfsr[3];
    mux_re  = s1_data[2*DW-1:DW];
    mux_im  = s1_data[DW-1:0];
    if (s1_bin == 6'd0 || s1_bin inside {[6'd27:6'd37]}) begin
      mux_re = '0;
      mux_im = '0;
    end else if (s1_bin == 6'd7 || s1_bin == 6'd43 || s1_bin == 6'd57) begin
      mux_re = pil_neg ? AMP_NEG : AMP_POS;
      mux_im = '0;
    end else if (s1_bin == 6'd21) begin
      mux_re = pil_neg ? AMP_POS : AMP_NEG;
      mux_im = '0;
    end
  end

endmodule
